// File: rtl/shift_reg_piso_frame_pkg.sv
// Shared definitions for the shift-register family (PISO frame core now,
// SIPO and universal variants later).
//   state_t : frame FSM encoding (idle / shifting)
//   DIR_*   : bit-order selectors for the MSB_FIRST parameter
package shift_reg_piso_frame_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DIR_MSB = 1;
  localparam int DIR_LSB = 0;

endpackage

// File: rtl/shift_reg_bit_cnt.sv
// Frame bit counter: down-counter that loads WIDTH-1, decrements on enable
// and parks at zero (never wraps).
// Ports:
//   clk, reset_n : clock, async active-low reset (count clears to 0)
//   load         : reload count to WIDTH-1 (wins over en)
//   en           : decrement by one when not already zero
//   zero         : count is zero
module shift_reg_bit_cnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_reg_piso_frame.sv
// Framed parallel-to-serial shift register with simultaneous serial capture.
// A word is loaded through a valid/ready handshake, shifted out on sdo one
// bit per shift_en tick, while sdi is shifted into the vacated end; the
// captured word is presented on q with a one-cycle q_valid pulse.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   d, load_valid         : parallel word offer
//   load_ready            : word accepted on this edge if load_valid
//   shift_en              : bit tick, one shift per high cycle while busy
//   sdi / sdo             : serial in / serial out
//   busy                  : frame in progress
//   q, q_valid            : last captured word, pulse on update
//
// state    | meaning
// ST_IDLE  | no frame; sdo at IDLE_LEVEL, ready for a word
// ST_SHIFT | frame active; sdo carries the current bit
module shift_reg_piso_frame
  import shift_reg_piso_frame_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             sdi,
  output logic             sdo,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             cnt_zero;
  logic             load_acc;
  logic             shift_ev;

  assign busy     = (state == ST_SHIFT);
  // Ready also on the final shift edge so the next word follows with no gap.
  assign load_ready = (state == ST_IDLE) || (cnt_zero && shift_en);
  assign load_acc   = load_valid && load_ready;
  assign shift_ev   = busy && shift_en;

  generate
    if (MSB_FIRST == DIR_LSB) begin : g_lsb
      assign shifted = {sdi, sreg[WIDTH-1:1]};
      assign sdo     = busy ? sreg[0] : IDLE_LEVEL;
    end else begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], sdi};
      assign sdo     = busy ? sreg[WIDTH-1] : IDLE_LEVEL;
    end
  endgenerate

  shift_reg_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_acc),
    .en      (shift_ev),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      if (shift_ev) begin
        sreg <= shifted;
        if (cnt_zero) begin
          q       <= shifted;
          q_valid <= 1'b1;
          if (!load_acc) begin
            state <= ST_IDLE;
          end
        end
      end
      // A load on the final shift edge overrides the shifted value.
      if (load_acc) begin
        sreg  <= d;
        state <= ST_SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_frame.sv
module tb_shift_reg_piso_frame;

  logic       clk = 1'b0;
  logic       reset_n;

  logic [3:0] a_d, a_q;
  logic       a_load_valid, a_load_ready, a_shift_en, a_sdi, a_sdo, a_busy, a_q_valid;

  logic [7:0] b_d, b_q;
  logic       b_load_valid, b_load_ready, b_shift_en, b_sdi, b_sdo, b_busy, b_q_valid;

  int         checks = 0;
  int         errors = 0;
  logic [31:0] pat;

  always #5 clk = ~clk;

  assign b_sdi = b_sdo;

  shift_reg_piso_frame #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .d(a_d), .load_valid(a_load_valid),
    .load_ready(a_load_ready), .shift_en(a_shift_en), .sdi(a_sdi), .sdo(a_sdo),
    .busy(a_busy), .q(a_q), .q_valid(a_q_valid)
  );

  shift_reg_piso_frame #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .d(b_d), .load_valid(b_load_valid),
    .load_ready(b_load_ready), .shift_en(b_shift_en), .sdi(b_sdi), .sdo(b_sdo),
    .busy(b_busy), .q(b_q), .q_valid(b_q_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    a_d = '0; a_load_valid = 1'b0; a_shift_en = 1'b0; a_sdi = 1'b0;
    b_d = '0; b_load_valid = 1'b0; b_shift_en = 1'b0;
    #2;
    chk("rst_a_busy",  32'(a_busy), 32'd0);
    chk("rst_a_sdo",   32'(a_sdo), 32'd0);
    chk("rst_a_q",     32'(a_q), 32'd0);
    chk("rst_a_ready", 32'(a_load_ready), 32'd1);
    chk("rst_a_qv",    32'(a_q_valid), 32'd0);
    chk("rst_b_sdo",   32'(b_sdo), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // MSB first, WIDTH 4, d=0101, sdi=1
    a_d = 4'b0101; a_load_valid = 1'b1; a_shift_en = 1'b1; a_sdi = 1'b1;
    @(posedge clk); #1;
    a_load_valid = 1'b0;
    chk("t2_busy",  32'(a_busy), 32'd1);
    chk("t2_ready", 32'(a_load_ready), 32'd0);
    pat = 32'b0101;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("t2_sdo", 32'(a_sdo), (pat >> (3 - k)) & 32'd1);
      chk("t2_qv_low", 32'(a_q_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("t2_qv",   32'(a_q_valid), 32'd1);
    chk("t2_q",    32'(a_q), 32'hF);
    chk("t2_busy_fall", 32'(a_busy), 32'd0);
    chk("t2_sdo_idle",  32'(a_sdo), 32'd0);
    @(posedge clk); #1;
    chk("t2_qv_pulse", 32'(a_q_valid), 32'd0);
    chk("t2_q_hold",   32'(a_q), 32'hF);
    chk("t2_idle_shift_ignored", 32'(a_busy), 32'd0);

    // LSB first, WIDTH 8, loopback, d=A5
    chk("t3_sdo_idle", 32'(b_sdo), 32'd1);
    b_d = 8'hA5; b_load_valid = 1'b1; b_shift_en = 1'b1;
    @(posedge clk); #1;
    b_load_valid = 1'b0;
    pat = 32'hA5;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("t3_sdo", 32'(b_sdo), (pat >> k) & 32'd1);
    end
    @(posedge clk); #1;
    chk("t3_qv",   32'(b_q_valid), 32'd1);
    chk("t3_q",    32'(b_q), 32'hA5);
    chk("t3_busy", 32'(b_busy), 32'd0);
    chk("t3_sdo_idle_after", 32'(b_sdo), 32'd1);
    b_shift_en = 1'b0;

    // shift_en toggling, d=1100, load_valid held during frame
    a_d = 4'b1100; a_load_valid = 1'b1; a_shift_en = 1'b0; a_sdi = 1'b0;
    @(posedge clk); #1;
    a_d = 4'b0011;
    pat = 32'hC;
    chk("t4_sdo0", 32'(a_sdo), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      a_shift_en = ((k % 2) == 0);
      if (k == 8) a_load_valid = 1'b0;
      #1;
      chk("t4_ready", 32'(a_load_ready), (k == 8) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (k < 8) begin
        chk("t4_sdo", 32'(a_sdo), (pat >> (3 - k / 2)) & 32'd1);
        chk("t4_qv_low", 32'(a_q_valid), 32'd0);
      end else begin
        chk("t4_qv",   32'(a_q_valid), 32'd1);
        chk("t4_q",    32'(a_q), 32'h0);
        chk("t4_busy", 32'(a_busy), 32'd0);
      end
    end

    // back-to-back frames 9 then 6
    a_d = 4'h9; a_load_valid = 1'b1; a_shift_en = 1'b1; a_sdi = 1'b1;
    @(posedge clk); #1;
    a_d = 4'h6;
    pat = 32'h96;
    chk("t5_sdo", 32'(a_sdo), (pat >> 7) & 32'd1);
    chk("t5_busy", 32'(a_busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 4) a_load_valid = 1'b0;
      chk("t5_qv", 32'(a_q_valid), ((k == 4) || (k == 8)) ? 32'd1 : 32'd0);
      chk("t5_busy", 32'(a_busy), (k < 8) ? 32'd1 : 32'd0);
      if (k < 8) chk("t5_sdo", 32'(a_sdo), (pat >> (7 - k)) & 32'd1);
    end
    chk("t5_q", 32'(a_q), 32'hF);

    // reset in the middle of a frame
    a_d = 4'b0101; a_load_valid = 1'b1; a_shift_en = 1'b1;
    @(posedge clk); #1;
    a_load_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_busy_pre", 32'(a_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t1_busy",  32'(a_busy), 32'd0);
    chk("t1_sdo",   32'(a_sdo), 32'd0);
    chk("t1_q",     32'(a_q), 32'd0);
    chk("t1_ready", 32'(a_load_ready), 32'd1);
    @(posedge clk); #1;
    chk("t1_busy_held", 32'(a_busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t1_no_qv", 32'(a_q_valid), 32'd0);
      chk("t1_idle",  32'(a_busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
